// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM encodings and constants for the bit-serial subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub_state_e;

    // Subtraction is A + ~B + 1, so the carry chain starts at one.
    localparam logic SUB_CIN = 1'b1;

endpackage

// File: rtl/sub_bit_cell.sv
// rtl/sub_bit_cell.sv - one-bit subtract cell producing propagate, generate, difference and carry
// A, B, Cin : operand bits and incoming carry
// p, q      : propagate (A ^ ~B) and generate (A & ~B)
// Diff, Cout: difference bit and outgoing carry
module sub_bit_cell (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic p,
    output logic q,
    output logic Diff,
    output logic Cout
);

    logic b_n;

    always_comb begin
        b_n  = ~B;
        p    = A ^ b_n;
        q    = A & b_n;
        Diff = p ^ Cin;
        Cout = q | (p & Cin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first, start/done handshake
// clk, rst_n          : clock, asynchronous active-low reset
// start, a, b         : request and operands, sampled in IDLE
// busy, done          : SHIFT indicator, one-cycle completion pulse
// diff, borrow_out,
// overflow            : registered result and flags, held until the next final edge
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Only WIDTH-1 partial bits are stored: the last difference bit goes
    // straight from the cell into diff on the final edge.
    logic [WIDTH-2:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic cell_p, cell_q, cell_d, cell_cout;
    // p/q are part of the shared cell interface; the serial path only needs Diff/Cout.
    logic cell_pq_unused;

    sub_bit_cell u_cell (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .p    (cell_p),
        .q    (cell_q),
        .Diff (cell_d),
        .Cout (cell_cout)
    );

    assign cell_pq_unused = cell_p & cell_q;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    carry_d = SUB_CIN;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = res_q >> 1;
                res_d[WIDTH-2] = cell_d;
                carry_d = cell_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    diff_d   = {cell_d, res_q};
                    borrow_d = ~cell_cout;
                    // carry_q is the carry into the MSB at this point.
                    ovf_d    = carry_q ^ cell_cout;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor, WIDTH=8
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at the negedge just after the accepting edge.
    task automatic finish_op(input string tag, input logic [7:0] ed, input logic eb, input logic eo);
        int cyc;
        cyc = 0;
        while (busy && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_cycles"}, cyc, 8);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_diff"}, diff, ed);
        check_eq({tag, "_borrow"}, borrow_out, eb);
        check_eq({tag, "_ovf"}, overflow, eo);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] prev, input logic [7:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        start = 1'b1;
        a = av;
        b = bv;
        @(negedge clk);
        start = 1'b0;
        // Operands are captured; later changes must not matter.
        a = ~av;
        b = 8'h5A;
        check_eq({tag, "_busy"}, busy, 1);
        check_eq({tag, "_hold"}, diff, prev);
        finish_op(tag, ed, eb, eo);
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;

        // Reset with start toggling: everything stays at zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = ~start;
            a = 8'h35;
            b = 8'h12;
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_diff", diff, 8'h00);
            check_eq("rst_flags", {borrow_out, overflow}, 2'b00);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", busy, 0);

        do_op("op_35_12", 8'h35, 8'h12, 8'h00, 8'h23, 1'b0, 1'b0);
        do_op("op_12_35", 8'h12, 8'h35, 8'h23, 8'hDD, 1'b1, 1'b0);
        do_op("op_80_01", 8'h80, 8'h01, 8'hDD, 8'h7F, 1'b0, 1'b1);

        // Reset after four SHIFT edges of 0x35-0x12.
        @(negedge clk);
        start = 1'b1;
        a = 8'h35;
        b = 8'h12;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_busy", busy, 0);
        check_eq("mid_done", done, 0);
        check_eq("mid_diff", diff, 8'h00);
        check_eq("mid_flags", {borrow_out, overflow}, 2'b00);
        repeat (2) begin
            @(negedge clk);
            check_eq("mid_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_released_busy", busy, 0);
        check_eq("mid_released_done", done, 0);

        do_op("op_fresh", 8'h35, 8'h12, 8'h00, 8'h23, 1'b0, 1'b0);
        do_op("op_00_00", 8'h00, 8'h00, 8'h23, 8'h00, 1'b0, 1'b0);

        // start held high; operands changed during busy.
        @(negedge clk);
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
        @(negedge clk);
        check_eq("held_busy", busy, 1);
        a = 8'hFF;
        b = 8'hFF;
        begin
            int cyc;
            cyc = 0;
            while (busy && cyc < 20) begin
                cyc++;
                @(negedge clk);
            end
            check_eq("held_busy_cycles", cyc, 8);
        end
        check_eq("held_done", done, 1);
        check_eq("held_diff", diff, 8'h0F);
        @(negedge clk);
        check_eq("held_idle_busy", busy, 0);
        check_eq("held_idle_done", done, 0);
        @(negedge clk);
        check_eq("held_second_busy", busy, 1);
        check_eq("held_second_hold", diff, 8'h0F);
        start = 1'b0;
        finish_op("held_second", 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
